// File: rtl/time_keeper.sv
// Time base and set-mode controller: keeps HH:MM:SS from clk, debounces three raw buttons and
// lets the user edit one decimal digit at a time while the display follows the cursor.
module time_keeper #(
  parameter int CLK_HZ    = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] pos,
  output logic       setting,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_SET} state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_sync1, r_sync2, r_db, r_press;
  logic [DW-1:0] r_db_cnt [3];

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ps, w_ps;
  logic [5:0]    r_hours, r_minutes, r_seconds, w_hours, w_minutes, w_seconds;
  logic [2:0]    r_pos, w_pos;
  logic          r_sec_tick, w_tick;
  logic          w_mode_ev, w_next_ev, w_inc_ev;

  assign w_raw = {btn_inc, btn_next, btn_mode};

  // Debounced level follows the synchronised input only after DB_CYCLES straight cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1, giving a true 2-FF chain.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [5:0] inc_units(input logic [5:0] f);
    logic [5:0] hi, lo;
    hi = f / 6'd10;
    lo = f % 6'd10;
    lo = (lo == 6'd9) ? 6'd0 : lo + 6'd1;
    return hi * 6'd10 + lo;
  endfunction

  function automatic logic [5:0] inc_tens(input logic [5:0] f);
    logic [5:0] hi, lo;
    hi = f / 6'd10;
    lo = f % 6'd10;
    hi = (hi == 6'd5) ? 6'd0 : hi + 6'd1;
    return hi * 6'd10 + lo;
  endfunction

  function automatic logic [5:0] inc_hour_low(input logic [5:0] f);
    logic [5:0] hi, lo;
    hi = f / 6'd10;
    lo = f % 6'd10;
    if ((hi == 6'd2 && lo >= 6'd3) || lo == 6'd9) lo = 6'd0;
    else                                          lo = lo + 6'd1;
    return hi * 6'd10 + lo;
  endfunction

  // Rolling the tens to 2 may leave an illegal 24..29, so the units clamp to 3.
  function automatic logic [5:0] inc_hour_high(input logic [5:0] f);
    logic [5:0] hi, lo;
    hi = f / 6'd10;
    lo = f % 6'd10;
    hi = (hi == 6'd2) ? 6'd0 : hi + 6'd1;
    if (hi == 6'd2 && lo > 6'd3) lo = 6'd3;
    return hi * 6'd10 + lo;
  endfunction

  assign w_mode_ev = r_press[0];
  assign w_next_ev = r_press[1] & ~r_press[0];
  assign w_inc_ev  = r_press[2] & ~r_press[1] & ~r_press[0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_ps        = r_ps;
    w_hours     = r_hours;
    w_minutes   = r_minutes;
    w_seconds   = r_seconds;
    w_pos       = r_pos;
    w_tick      = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_mode_ev) begin
          w_state_nxt = ST_SET;
          w_pos       = 3'd0;
          w_ps        = '0;
        end else if (r_ps == PS_LAST) begin
          w_ps   = '0;
          w_tick = 1'b1;
          if (r_seconds == 6'd59) begin
            w_seconds = 6'd0;
            if (r_minutes == 6'd59) begin
              w_minutes = 6'd0;
              w_hours   = (r_hours == 6'd23) ? 6'd0 : r_hours + 6'd1;
            end else begin
              w_minutes = r_minutes + 6'd1;
            end
          end else begin
            w_seconds = r_seconds + 6'd1;
          end
        end else begin
          w_ps = r_ps + 1'b1;
        end
      end
      ST_SET: begin
        w_ps = '0;
        if (w_mode_ev) begin
          w_state_nxt = ST_RUN;
          w_pos       = 3'd0;
        end else if (w_next_ev) begin
          w_pos = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;
        end else if (w_inc_ev) begin
          case (r_pos)
            3'd0:    w_seconds = inc_units(r_seconds);
            3'd1:    w_seconds = inc_tens(r_seconds);
            3'd2:    w_minutes = inc_units(r_minutes);
            3'd3:    w_minutes = inc_tens(r_minutes);
            3'd4:    w_hours   = inc_hour_low(r_hours);
            3'd5:    w_hours   = inc_hour_high(r_hours);
            default: w_pos     = 3'd0;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_ps       <= '0;
      r_hours    <= 6'd0;
      r_minutes  <= 6'd0;
      r_seconds  <= 6'd0;
      r_pos      <= 3'd0;
      r_sec_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ps       <= w_ps;
      r_hours    <= w_hours;
      r_minutes  <= w_minutes;
      r_seconds  <= w_seconds;
      r_pos      <= w_pos;
      r_sec_tick <= w_tick;
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign pos      = r_pos;
  assign setting  = (r_state == ST_SET);
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: a seconds-of-day reference model pushes expected display
// snapshots; a negedge monitor pops one whenever the displayed state changes or a tick pulses.
module tb_time_keeper;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_raw = 3'b000;  // [0]=mode [1]=next [2]=inc
  logic [5:0] hours, minutes, seconds;
  logic [2:0] pos;
  logic       setting, sec_tick;

  time_keeper #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_raw[0]), .btn_next(btn_raw[1]), .btn_inc(btn_raw[2]),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .pos(pos), .setting(setting), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] h, m, s;
    logic [2:0] pos;
    logic       set;
    logic       tick;
  } obs_t;

  typedef logic [5:0][3:0] dig_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_count = 0;
  bit   mon_en = 1'b0;

  // Reference model: whole time of day as seconds, plus mode and cursor.
  int m_tod = 0;
  bit m_set = 1'b0;
  int m_pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic dig_t to_digits(input int tod);
    dig_t d;
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    d[0] = 4'(s % 10); d[1] = 4'(s / 10);
    d[2] = 4'(m % 10); d[3] = 4'(m / 10);
    d[4] = 4'(h % 10); d[5] = 4'(h / 10);
    return d;
  endfunction

  function automatic int from_digits(input dig_t d);
    return (int'(d[5]) * 10 + int'(d[4])) * 3600 + (int'(d[3]) * 10 + int'(d[2])) * 60
           + int'(d[1]) * 10 + int'(d[0]);
  endfunction

  function automatic obs_t model_obs(input bit tick);
    obs_t o;
    o.h    = 6'(m_tod / 3600);
    o.m    = 6'((m_tod / 60) % 60);
    o.s    = 6'(m_tod % 60);
    o.pos  = 3'(m_pos);
    o.set  = m_set;
    o.tick = tick;
    return o;
  endfunction

  task automatic model_inc();
    dig_t d;
    int   v;
    d = to_digits(m_tod);
    v = int'(d[m_pos]);
    case (m_pos)
      0, 2: v = (v + 1) % 10;
      1, 3: v = (v + 1) % 6;
      4:    v = (v + 1) % ((d[5] == 4'd2) ? 4 : 10);
      default: v = (v + 1) % 3;
    endcase
    d[m_pos] = 4'(v);
    if (m_pos == 5 && d[5] == 4'd2 && d[4] > 4'd3) d[4] = 4'd3;
    m_tod = from_digits(d);
  endtask

  // Monitor: one scoreboard pop per observable change or tick pulse.
  obs_t cur, cur_nt, prev, prev_nt, e;
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {hours, minutes, seconds, pos, setting, sec_tick};
      if (cur.tick) begin
        tick_count++;
        check("tick_width", 32'(prev.tick), 32'd0);
      end
      cur_nt = cur;  cur_nt.tick = 1'b0;
      prev_nt = prev; prev_nt.tick = 1'b0;
      if (cur.tick || cur_nt != prev_nt) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event: got %0d:%0d:%0d pos=%0d set=%0d tick=%0d, required no change",
                   cur.h, cur.m, cur.s, cur.pos, cur.set, cur.tick);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_errors++;
            $display("FAIL obs: got %0d:%0d:%0d pos=%0d set=%0d tick=%0d, required %0d:%0d:%0d pos=%0d set=%0d tick=%0d",
                     cur.h, cur.m, cur.s, cur.pos, cur.set, cur.tick,
                     e.h, e.m, e.s, e.pos, e.set, e.tick);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic wait_setting(input logic v, input string name);
    int k = 0;
    while (setting !== v && k < 40) begin
      cyc(1);
      k++;
    end
    check(name, 32'(setting), 32'(v));
  endtask

  // Button press while in SET: model update and expectation first, then the raw waveform.
  task automatic press(input int idx, input int hold);
    if (idx == 1) m_pos = (m_pos + 1) % 6;
    else          model_inc();
    exp_q.push_back(model_obs(1'b0));
    btn_raw[idx] = 1'b1;
    cyc(hold);
    btn_raw[idx] = 1'b0;
    cyc(12);
  endtask

  // Called just after a tick/exit/reset edge so the entry lands before the next second.
  task automatic enter_set();
    m_set = 1'b1;
    m_pos = 0;
    exp_q.push_back(model_obs(1'b0));
    btn_raw[0] = 1'b1;
    wait_setting(1'b1, "enter_set");
    btn_raw[0] = 1'b0;
    cyc(12);
  endtask

  task automatic exit_set(input logic [2:0] mask, input int n);
    m_set = 1'b0;
    m_pos = 0;
    exp_q.push_back(model_obs(1'b0));
    btn_raw = mask;
    wait_setting(1'b0, "exit_set");
    btn_raw = 3'b000;
    for (int k = 0; k < n; k++) begin
      m_tod = (m_tod + 1) % 86400;
      exp_q.push_back(model_obs(1'b1));
    end
    cyc(10 * n);
  endtask

  task automatic goto_pos(input int p);
    int k = 0;
    while (m_pos != p && k < 6) begin
      press(1, 10);
      k++;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    dig_t t, d;
    int   k;
    t = to_digits(h * 3600 + m * 60 + s);
    goto_pos(5);
    d = to_digits(m_tod);
    k = 0;
    while (d[5] != 4'd0 && k < 3) begin
      press(2, 10);
      d = to_digits(m_tod);
      k++;
    end
    for (int p = 0; p < 6; p++) begin
      goto_pos(p);
      d = to_digits(m_tod);
      k = 0;
      while (d[p] != t[p] && k < 10) begin
        press(2, 10);
        d = to_digits(m_tod);
        k++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prev = '0;
    rst  = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("rst_hours", 32'(hours), 32'd0);
    check("rst_minutes", 32'(minutes), 32'd0);
    check("rst_seconds", 32'(seconds), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_setting", 32'(setting), 32'd0);
    check("rst_tick", 32'(sec_tick), 32'd0);
    mon_en = 1'b1;

    // 600 cycles of free running: one minute.
    for (int k = 0; k < 60; k++) begin
      m_tod++;
      exp_q.push_back(model_obs(1'b1));
    end
    cyc(600);
    enter_set();
    check("ticks_in_600", 32'(tick_count), 32'd60);
    check("minute_after_600", 32'(minutes), 32'd1);
    check("second_after_600", 32'(seconds), 32'd0);

    // Cursor walk 1,2,3,4,5,0 with time frozen.
    for (int k = 0; k < 6; k++) press(1, 10);

    // Midnight rollover on the first tick after leaving SET.
    set_time(23, 59, 59);
    exit_set(3'b001, 2);

    // Digit-edit corners: hour_low wrap at 23, hour_high clamp from 19, seconds units wrap.
    enter_set();
    set_time(23, 59, 59);
    goto_pos(4);
    press(2, 10);
    check("h23_pos4_inc", 32'(hours), 32'd20);
    set_time(19, 59, 59);
    goto_pos(5);
    press(2, 10);
    check("h19_pos5_inc", 32'(hours), 32'd23);
    goto_pos(0);
    press(2, 10);
    check("s59_pos0_inc", 32'(seconds), 32'd50);

    // Random edit traffic inside SET.
    for (int k = 0; k < 30; k++) begin
      press(($urandom_range(0, 9) < 4) ? 1 : 2, int'($urandom_range(8, 16)));
    end

    // Short glitch is ignored; a long hold gives exactly one increment.
    btn_raw[2] = 1'b1;
    cyc(3);
    btn_raw[2] = 1'b0;
    cyc(15);
    check("glitch_no_event", 32'(exp_q.size()), 32'd0);
    press(2, 20);

    // Mode and inc landing together: only mode acts.
    exit_set(3'b101, 2);

    // Reset in the middle of an edit at pos 3.
    enter_set();
    goto_pos(3);
    m_tod = 0;
    m_set = 1'b0;
    m_pos = 0;
    exp_q.push_back(model_obs(1'b0));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midset_rst_setting", 32'(setting), 32'd0);
    check("midset_rst_pos", 32'(pos), 32'd0);
    check("midset_rst_time", {8'd0, hours, minutes, seconds}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      m_tod++;
      exp_q.push_back(model_obs(1'b1));
    end
    cyc(30);

    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 50) begin
        cyc(1);
        k++;
      end
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
